logic_op_pipe: RTL and testbench
================================

# logic_op_pipe

Parametrised, multi-bit successor to the single-bit registered XOR cell. It registers two WIDTH-bit operands and an operation code, applies a selectable bitwise operation, and carries the result through a configurable pipeline with valid/ready flow control. It also keeps a saturating count of output transfers whose value differs from the previous transfer. It sits between registered datapath sources and any downstream consumer that can apply backpressure.

## Interface
- WIDTH, 8: operand/result width in bits, 1..64.
- DEPTH, 2: number of result register stages after the input stage, 1..8.
- CNT_W, 16: width of the change counter, 4..32.

- clk  in  1  clock; all logic is rising-edge.
- rst_reg  in  1  reset; asynchronous, active-high.
- srst  in  1  synchronous clear; active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  operation: 00 XOR, 01 AND, 10 OR, 11 XNOR.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts a beat.
- c  out  WIDTH  result.
- chg_cnt  out  CNT_W  saturating count of changed output transfers.

## Operation
- Pipeline: stage S0 holds registered a, b, op and a valid bit. Stages S1..S_DEPTH hold a result and a valid bit.
  - S1 loads f(op, a, b) computed from S0.
  - c and out_valid are driven from S_DEPTH.
- Advance: adv = !out_valid || out_ready.
  - When adv = 1, every stage shifts one position.
  - S0 loads a, b, op and valid = (in_valid && in_ready).
  - When adv = 0, all stages hold.
  - Bubbles are not collapsed.
- in_ready = adv, forced to 0 while rst_reg or srst is high.
- Transfers: an input beat transfers on in_valid && in_ready; an output beat transfers on out_valid && out_ready.
- Stage data: loaded even when the stage's valid bit is 0. Only valid bits gate transfers.
- Change counter:
  - A register last_c holds the value of the most recent output transfer; its reset value is 0.
  - On each output transfer, last_c is updated to c.
  - If c != last_c, chg_cnt increments by 1, saturating at 2^CNT_W-1.
- Priority, per edge: rst_reg (async) > srst > normal operation.
  - Both resets clear all valid bits, stage data, last_c and chg_cnt to 0.
- Reset mid-operation: all in-flight beats are discarded with no output transfer. The counter returns to 0.
- op is sampled with its operands. A change of op between beats affects only beats accepted afterwards.

## Timing
- Reset values:
  - out_valid = 0
  - c = 0
  - chg_cnt = 0
  - in_ready = 0 while reset is asserted; 1 in the first cycle after release.
- Latency: a beat accepted in cycle 0, with out_ready held high, has out_valid = 1 in cycle DEPTH+1.
- Throughput: one beat per cycle while out_ready = 1.
- Stall: out_valid = 0 and out_ready = 0 together is not a stall, because adv = 1.
  - A stall occurs only when out_valid = 1 and out_ready = 0.
  - During a stall, c, out_valid and all stages hold and in_ready = 0.
  - Release: in_ready rises combinationally in the same cycle out_ready rises.
- Pipeline capacity: DEPTH+1 beats; no beat is lost or duplicated under any out_ready pattern.
- chg_cnt: updates on the edge ending the output transfer and is visible in the next cycle.
  - Simultaneous srst and output transfer: srst wins; the counter goes to 0 and last_c goes to 0.
- in_ready depends combinationally on out_ready; there is no combinational path from in_valid or a/b to any output.

## Test plan
- Basic ops: WIDTH=8, DEPTH=2, out_ready=1. Drive beats a=0xF0, b=0x3C with op 00/01/10/11 in cycles 0..3.
  - Expect c = 0xCC, 0x30, 0xFC, 0x33 in cycles 3..6, with out_valid high in cycles 3..6 only.
- Backpressure: stream 10 beats (a=i, b=0, op=00) with out_ready toggling 1,0,0,1 repeatedly.
  - Expect outputs 0..9 in order with no loss or duplication, and in_ready = 0 in every cycle where out_valid=1 and out_ready=0.
- Change counter: output values 0x00, 0x05, 0x05, 0x0A, 0x00 transferred → chg_cnt = 3. With CNT_W=4, 20 alternating values → chg_cnt saturates at 15.
- Async reset mid-stream: assert rst_reg between edges with 3 beats in flight.
  - Expect out_valid, c and chg_cnt = 0 immediately, no further output transfer, and in_ready = 1 one cycle after release.
- Sync clear: assert srst for one cycle during a stall with the pipeline full.
  - Expect all valids cleared at that edge and chg_cnt = 0.
  - The next accepted beat appears DEPTH+1 cycles later.
- Parameter sweep: DEPTH ∈ {1, 8}, WIDTH ∈ {1, 64}, random a/b/op and random out_ready.
  - Results are checked against a reference queue, with latency exactly DEPTH+1 when out_ready=1.

Source files
------------

// File: rtl/logic_op_pipe.sv
// logic_op_pipe: registers two operands and an op code, applies a selectable
// bitwise operation and carries the result through a DEPTH-stage pipeline
// with valid/ready flow control. Also keeps a saturating count of output
// transfers whose value differs from the previous transfer.
module logic_op_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_reg,
  input  logic             srst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [CNT_W-1:0] chg_cnt
);

  typedef enum logic [1:0] {
    OP_XOR  = 2'b00,
    OP_AND  = 2'b01,
    OP_OR   = 2'b10,
    OP_XNOR = 2'b11
  } op_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Input stage S0: operands, op code and valid bit
  logic [WIDTH-1:0] r_s0A;
  logic [WIDTH-1:0] r_s0B;
  op_e              r_s0Op;
  logic             r_s0Valid;

  // Result stages S1..S_DEPTH, index 0 is S1
  logic [WIDTH-1:0] r_stgData [DEPTH];
  logic [DEPTH-1:0] r_stgValid;

  // Change counter state
  logic [WIDTH-1:0] r_lastC;
  logic [CNT_W-1:0] r_chgCnt;

  logic             w_adv;
  logic             w_outXfer;
  logic [WIDTH-1:0] w_opResult;

  // The whole pipeline moves unless a valid result is waiting on the consumer
  always_comb begin
    w_adv     = !r_stgValid[DEPTH-1] || out_ready;
    in_ready  = w_adv && !rst_reg && !srst;
    w_outXfer = r_stgValid[DEPTH-1] && out_ready;
  end

  // Bitwise operation selected by the op code captured with the operands
  always_comb begin
    w_opResult = '0;
    unique case (r_s0Op)
      OP_XOR:  w_opResult = r_s0A ^ r_s0B;
      OP_AND:  w_opResult = r_s0A & r_s0B;
      OP_OR:   w_opResult = r_s0A | r_s0B;
      OP_XNOR: w_opResult = ~(r_s0A ^ r_s0B);
    endcase
  end

  // S0 captures the inputs on every advance; valid marks a real input transfer
  always_ff @(posedge clk or posedge rst_reg) begin
    if (rst_reg) begin
      r_s0A     <= '0;
      r_s0B     <= '0;
      r_s0Op    <= OP_XOR;
      r_s0Valid <= 1'b0;
    end else if (srst) begin
      r_s0A     <= '0;
      r_s0B     <= '0;
      r_s0Op    <= OP_XOR;
      r_s0Valid <= 1'b0;
    end else if (w_adv) begin
      r_s0A     <= a;
      r_s0B     <= b;
      r_s0Op    <= op_e'(op);
      r_s0Valid <= in_valid && in_ready;
    end
  end

  // Result stages shift as one block; bubbles travel along with real beats
  always_ff @(posedge clk or posedge rst_reg) begin
    if (rst_reg) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stgData[i] <= '0;
      end
      r_stgValid <= '0;
    end else if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_stgData[i] <= '0;
      end
      r_stgValid <= '0;
    end else if (w_adv) begin
      r_stgData[0]  <= w_opResult;
      r_stgValid[0] <= r_s0Valid;
      for (int i = 1; i < DEPTH; i++) begin
        r_stgData[i]  <= r_stgData[i-1];
        r_stgValid[i] <= r_stgValid[i-1];
      end
    end
  end

  // Count output transfers that differ from the previous transfer, saturating
  always_ff @(posedge clk or posedge rst_reg) begin
    if (rst_reg) begin
      r_lastC  <= '0;
      r_chgCnt <= '0;
    end else if (srst) begin
      r_lastC  <= '0;
      r_chgCnt <= '0;
    end else if (w_outXfer) begin
      r_lastC <= r_stgData[DEPTH-1];
      if ((r_stgData[DEPTH-1] != r_lastC) && (r_chgCnt != CNT_MAX)) begin
        r_chgCnt <= r_chgCnt + 1'b1;
      end
    end
  end

  assign out_valid = r_stgValid[DEPTH-1];
  assign c         = r_stgData[DEPTH-1];
  assign chg_cnt   = r_chgCnt;

endmodule

// File: tb/tb_logic_op_pipe.sv
// tb_logic_op_pipe: drives three differently parameterised logic_op_pipe
// instances from shared stimulus and compares them against a queue-based
// reference model of in-flight beats.
module tb_logic_op_pipe;

  logic        clk = 1'b0;
  logic        rst_reg;
  logic        srst;
  logic        stimInValid;
  logic [63:0] stimA;
  logic [63:0] stimB;
  logic [1:0]  stimOp;
  logic        stimOutReady;

  logic        ir0, ov0, ir1, ov1, ir2, ov2;
  logic [7:0]  c0;
  logic [0:0]  c1;
  logic [63:0] c2;
  logic [15:0] cnt0;
  logic [3:0]  cnt1;
  logic [3:0]  cnt2;

  logic        obsOV [3];
  logic        obsIR [3];
  logic [63:0] obsC [3];
  logic [31:0] obsCnt [3];

  int numChecks = 0;
  int numFails  = 0;

  // Model configuration per instance
  int depths [3] = '{2, 1, 8};
  int widths [3] = '{8, 1, 64};
  int cntMax [3] = '{65535, 15, 15};

  typedef struct {
    int          dut;
    logic [63:0] val;
    int          pos;
  } beat_t;

  beat_t       flight [$];
  logic [63:0] lastC [3];
  int          cnt [3];
  logic [63:0] capC [$];
  logic        acc0;

  // Free-running clock
  always #5 clk = ~clk;

  logic_op_pipe #(.WIDTH(8), .DEPTH(2), .CNT_W(16)) dut0 (
    .clk(clk), .rst_reg(rst_reg), .srst(srst), .in_valid(stimInValid), .in_ready(ir0),
    .a(stimA[7:0]), .b(stimB[7:0]), .op(stimOp), .out_valid(ov0), .out_ready(stimOutReady),
    .c(c0), .chg_cnt(cnt0));

  logic_op_pipe #(.WIDTH(1), .DEPTH(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_reg(rst_reg), .srst(srst), .in_valid(stimInValid), .in_ready(ir1),
    .a(stimA[0:0]), .b(stimB[0:0]), .op(stimOp), .out_valid(ov1), .out_ready(stimOutReady),
    .c(c1), .chg_cnt(cnt1));

  logic_op_pipe #(.WIDTH(64), .DEPTH(8), .CNT_W(4)) dut2 (
    .clk(clk), .rst_reg(rst_reg), .srst(srst), .in_valid(stimInValid), .in_ready(ir2),
    .a(stimA), .b(stimB), .op(stimOp), .out_valid(ov2), .out_ready(stimOutReady),
    .c(c2), .chg_cnt(cnt2));

  // Gather outputs into uniform arrays for the model loop
  assign obsOV[0]  = ov0;
  assign obsOV[1]  = ov1;
  assign obsOV[2]  = ov2;
  assign obsIR[0]  = ir0;
  assign obsIR[1]  = ir1;
  assign obsIR[2]  = ir2;
  assign obsC[0]   = {56'd0, c0};
  assign obsC[1]   = {63'd0, c1};
  assign obsC[2]   = c2;
  assign obsCnt[0] = {16'd0, cnt0};
  assign obsCnt[1] = {28'd0, cnt1};
  assign obsCnt[2] = {28'd0, cnt2};

  // Count one comparison and report it if it does not match
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    numChecks++;
    if (got !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference operation masked to the instance width
  function automatic logic [63:0] refOp(input logic [1:0] o, input logic [63:0] x,
                                        input logic [63:0] y, input int w);
    logic [63:0] r;
    logic [63:0] m;
    case (o)
      2'b00:   r = x ^ y;
      2'b01:   r = x & y;
      2'b10:   r = x | y;
      default: r = ~(x ^ y);
    endcase
    m = (w >= 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
    return r & m;
  endfunction

  // Drop every in-flight beat of one instance and clear its counter state
  task automatic clearModel(input int k);
    beat_t keep [$];
    keep = {};
    foreach (flight[j]) if (flight[j].dut != k) keep.push_back(flight[j]);
    flight   = keep;
    lastC[k] = '0;
    cnt[k]   = 0;
  endtask

  // Apply one cycle of inputs, check all instances before the edge, then
  // advance the model to what the edge will do
  task automatic applyStimulus(input logic iv, input logic [63:0] ia, input logic [63:0] ib,
                               input logic [1:0] iop, input logic ordy, input logic isr,
                               input logic irst);
    logic        expOV;
    logic        expIR;
    logic [63:0] expC;
    int          headIdx;
    stimInValid  = iv;
    stimA        = ia;
    stimB        = ib;
    stimOp       = iop;
    stimOutReady = ordy;
    srst         = isr;
    rst_reg      = irst;
    #2;
    acc0 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (irst) clearModel(k);
      expOV   = 1'b0;
      expC    = '0;
      headIdx = -1;
      foreach (flight[j]) begin
        if (flight[j].dut == k && flight[j].pos == depths[k]) begin
          expOV   = 1'b1;
          expC    = flight[j].val;
          headIdx = j;
        end
      end
      expIR = (!expOV || ordy) && !isr && !irst;
      checkOutput($sformatf("d%0d_out_valid", k), {63'd0, obsOV[k]}, {63'd0, expOV});
      checkOutput($sformatf("d%0d_in_ready", k), {63'd0, obsIR[k]}, {63'd0, expIR});
      checkOutput($sformatf("d%0d_chg_cnt", k), {32'd0, obsCnt[k]}, 64'(cnt[k]));
      if (expOV || irst) checkOutput($sformatf("d%0d_c", k), obsC[k], expC);
      if (isr || irst) begin
        clearModel(k);
      end else if (!expOV || ordy) begin
        if (expOV) begin
          if (expC != lastC[k] && cnt[k] < cntMax[k]) cnt[k]++;
          lastC[k] = expC;
          if (k == 0) capC.push_back(expC);
          flight.delete(headIdx);
        end
        foreach (flight[j]) if (flight[j].dut == k) flight[j].pos++;
        if (iv) flight.push_back('{k, refOp(iop, ia, ib, widths[k]), 0});
        if (k == 0) acc0 = iv;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b0, 1'b0);
  endtask

  logic [7:0] opsExp [4] = '{8'hCC, 8'h30, 8'hFC, 8'h33};
  logic [7:0] chgVals [5] = '{8'h00, 8'h05, 8'h05, 8'h0A, 8'h00};

  initial begin
    int i;
    int cyc;
    int n;
    for (int k = 0; k < 3; k++) begin
      lastC[k] = '0;
      cnt[k]   = 0;
    end

    // Reset held for two cycles, then released
    applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(2);

    // Basic operations with the consumer always ready
    capC.delete();
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 64'hF0, 64'h3C, 2'(j), 1'b1, 1'b0, 1'b0);
    idle(12);
    checkOutput("ops_count", 64'(capC.size()), 64'd4);
    for (int j = 0; j < 4 && j < capC.size(); j++) checkOutput("ops_value", capC[j], {56'd0, opsExp[j]});

    // Backpressure with out_ready toggling 1,0,0,1
    capC.delete();
    i = 0;
    cyc = 0;
    while ((i < 10 || capC.size() < 10) && cyc < 200) begin
      applyStimulus(i < 10, 64'(i), 64'd0, 2'b00, (cyc % 4 == 0) || (cyc % 4 == 3), 1'b0, 1'b0);
      if (acc0) i++;
      cyc++;
    end
    checkOutput("bp_count", 64'(capC.size()), 64'd10);
    for (int j = 0; j < 10 && j < capC.size(); j++) checkOutput("bp_order", capC[j], 64'(j));
    idle(12);

    // Change counter on a known value sequence
    applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 5; j++) applyStimulus(1'b1, {56'd0, chgVals[j]}, 64'd0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(12);
    checkOutput("chg_directed", {32'd0, obsCnt[0]}, 64'd3);

    // Saturation with alternating values
    applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b1, 1'b0);
    for (int j = 0; j < 20; j++) applyStimulus(1'b1, (j % 2 == 0) ? 64'd1 : 64'd2, 64'd0, 2'b00, 1'b1, 1'b0, 1'b0);
    idle(12);
    checkOutput("sat_w8", {32'd0, obsCnt[0]}, 64'd20);
    checkOutput("sat_w1", {32'd0, obsCnt[1]}, 64'd15);
    checkOutput("sat_w64", {32'd0, obsCnt[2]}, 64'd15);

    // Asynchronous reset with three beats in flight
    for (int j = 0; j < 3; j++) applyStimulus(1'b1, 64'h11 + 64'(j), 64'h0F, 2'b10, 1'b1, 1'b0, 1'b0);
    capC.delete();
    rst_reg = 1'b1;
    #1;
    checkOutput("arst_out_valid", {63'd0, obsOV[0]}, 64'd0);
    checkOutput("arst_c", obsC[0], 64'd0);
    checkOutput("arst_chg_cnt", {32'd0, obsCnt[0]}, 64'd0);
    applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b0, 1'b1);
    idle(10);
    checkOutput("arst_no_xfer", 64'(capC.size()), 64'd0);

    // Synchronous clear during a full stall, then latency of the next beat
    for (int j = 0; j < 5; j++) applyStimulus(1'b1, 64'h40 + 64'(j), 64'h01, 2'b00, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 64'h77, 64'h00, 2'b00, 1'b0, 1'b1, 1'b0);
    checkOutput("srst_out_valid", {63'd0, obsOV[0]}, 64'd0);
    checkOutput("srst_chg_cnt", {32'd0, obsCnt[0]}, 64'd0);
    capC.delete();
    applyStimulus(1'b1, 64'h5A, 64'hFF, 2'b01, 1'b1, 1'b0, 1'b0);
    n = 0;
    while (capC.size() == 0 && n < 20) begin
      n++;
      applyStimulus(1'b0, 64'd0, 64'd0, 2'b00, 1'b1, 1'b0, 1'b0);
    end
    checkOutput("srst_latency", 64'(n), 64'd3);
    if (capC.size() > 0) checkOutput("srst_value", capC[0], 64'h5A);
    idle(12);

    // Random traffic across all three parameter sets
    for (int j = 0; j < 1500; j++) begin
      applyStimulus($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                    2'($urandom_range(0, 3)), (j % 200 < 60) || ($urandom_range(0, 9) < 6),
                    $urandom_range(0, 199) == 0, 1'b0);
    end
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
    $finish;
  end

endmodule
